mdu_seq: RTL

//  Multi-cycle multiply/divide unit; companion and successor to the single-cycle ALU in the execute stage.

---
 rtl/mdu_pkg.sv | 44 ++++
 rtl/mdu_calc.sv | 99 +++++++++
 rtl/mdu_seq.sv | 112 +++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings, default latencies and state type for the multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a; consumers use the op-class helpers to steer launch/stall decisions.
package mdu_pkg;

   // MDUOp encodings
   localparam logic [2:0] MDU_MULT  = 3'd0;
   localparam logic [2:0] MDU_MULTU = 3'd1;
   localparam logic [2:0] MDU_DIV   = 3'd2;
   localparam logic [2:0] MDU_DIVU  = 3'd3;
   localparam logic [2:0] MDU_MTHI  = 3'd4;
   localparam logic [2:0] MDU_MTLO  = 3'd5;
   localparam logic [2:0] MDU_MADD  = 3'd6;
   localparam logic [2:0] MDU_MADDU = 3'd7;

   // Default geometry and latencies
   localparam int MDU_DEF_WIDTH       = 32;
   localparam int MDU_DEF_MULT_CYCLES = 5;
   localparam int MDU_DEF_DIV_CYCLES  = 10;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } mdu_state_t;

   // Ops that occupy the unit for a multi-cycle latency; madd/maddu only when built in.
   function automatic logic is_long_op(input logic [2:0] op);
      logic res;
      res = 1'b0;
      case (op)
         MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: res = 1'b1;
`ifdef MDU_MADD_EN
         MDU_MADD, MDU_MADDU:                    res = 1'b1;
`endif
         default:                                res = 1'b0;
      endcase
      return res;
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational result datapath: product, quotient/remainder, optional accumulate (MDU_MADD_EN).
// Latency: 0 cycles, purely combinational; the sequencer samples it on the launch edge.
// Backpressure: none; outputs simply follow inputs.
module mdu_calc
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_DEF_WIDTH
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_hi,
   input  logic [WIDTH-1:0] i_lo,
   output logic [WIDTH-1:0] o_hi_n,
   output logic [WIDTH-1:0] o_lo_n
);

   localparam logic [WIDTH-1:0] W_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] W_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   // Products: extend to 2*WIDTH first so the low 2*WIDTH bits are exact for both signednesses.
   logic [2*WIDTH-1:0] w_a_sx, w_b_sx, w_a_zx, w_b_zx;
   logic [2*WIDTH-1:0] w_prod_s, w_prod_u;

   assign w_a_sx   = {{WIDTH{i_a[WIDTH-1]}}, i_a};
   assign w_b_sx   = {{WIDTH{i_b[WIDTH-1]}}, i_b};
   assign w_a_zx   = {{WIDTH{1'b0}}, i_a};
   assign w_b_zx   = {{WIDTH{1'b0}}, i_b};
   assign w_prod_s = w_a_sx * w_b_sx;
   assign w_prod_u = w_a_zx * w_b_zx;

   // Division runs on magnitudes; the divisor is forced to 1 on B==0 so the
   // dividers never see zero (the zero case is overridden below anyway).
   logic             w_a_neg, w_b_neg, w_b_zero, w_ovf;
   logic [WIDTH-1:0] w_a_mag, w_b_mag, w_ds_b, w_du_b;
   logic [WIDTH-1:0] w_qs_mag, w_rs_mag, w_qs, w_rs, w_qu, w_ru;

   assign w_a_neg  = i_a[WIDTH-1];
   assign w_b_neg  = i_b[WIDTH-1];
   assign w_b_zero = (i_b == '0);
   assign w_ovf    = (i_a == W_MIN) && (i_b == '1);
   assign w_a_mag  = w_a_neg ? (~i_a + W_ONE) : i_a;
   assign w_b_mag  = w_b_neg ? (~i_b + W_ONE) : i_b;
   assign w_ds_b   = w_b_zero ? W_ONE : w_b_mag;
   assign w_du_b   = w_b_zero ? W_ONE : i_b;
   assign w_qs_mag = w_a_mag / w_ds_b;
   assign w_rs_mag = w_a_mag % w_ds_b;
   assign w_qs     = (w_a_neg ^ w_b_neg) ? (~w_qs_mag + W_ONE) : w_qs_mag;
   assign w_rs     = w_a_neg ? (~w_rs_mag + W_ONE) : w_rs_mag;
   assign w_qu     = i_a / w_du_b;
   assign w_ru     = i_a % w_du_b;

`ifdef MDU_MADD_EN
   // Accumulate onto the current HI/LO, wrapping mod 2^(2*WIDTH).
   logic [2*WIDTH-1:0] w_acc_s, w_acc_u;
   assign w_acc_s = {i_hi, i_lo} + w_prod_s;
   assign w_acc_u = {i_hi, i_lo} + w_prod_u;
`endif

   // Select the pending result for the requested op; unlisted ops pass HI/LO through.
   always_comb begin
      o_hi_n = i_hi;
      o_lo_n = i_lo;
      case (i_op)
         MDU_MULT:  {o_hi_n, o_lo_n} = w_prod_s;
         MDU_MULTU: {o_hi_n, o_lo_n} = w_prod_u;
         MDU_DIV: begin
            if (w_b_zero) begin
               o_hi_n = i_a;
               o_lo_n = '1;
            end else if (w_ovf) begin
               o_hi_n = '0;
               o_lo_n = W_MIN;
            end else begin
               o_hi_n = w_rs;
               o_lo_n = w_qs;
            end
         end
         MDU_DIVU: begin
            if (w_b_zero) begin
               o_hi_n = i_a;
               o_lo_n = '1;
            end else begin
               o_hi_n = w_ru;
               o_lo_n = w_qu;
            end
         end
`ifdef MDU_MADD_EN
         MDU_MADD:  {o_hi_n, o_lo_n} = w_acc_s;
         MDU_MADDU: {o_hi_n, o_lo_n} = w_acc_u;
`endif
         default: begin
            o_hi_n = i_hi;
            o_lo_n = i_lo;
         end
      endcase
   end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with HI/LO registers; madd/maddu when MDU_MADD_EN is defined.
// Latency: MULT_CYCLES (mult/madd) or DIV_CYCLES (div) busy cycles; mthi/mtlo write in 1 cycle.
// Backpressure: busy high while in flight; any start seen while busy is dropped, never queued.
module mdu_seq
   import mdu_pkg::*;
#(
   parameter int WIDTH       = MDU_DEF_WIDTH,
   parameter int MULT_CYCLES = MDU_DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = MDU_DEF_DIV_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       MDUOp,
   input  logic             start,
   output logic             busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   mdu_state_t       r_state, w_state_n;
   logic [CNT_W-1:0] r_cnt, w_load_cnt;
   logic [WIDTH-1:0] r_pend_hi, r_pend_lo, r_hi, r_lo;
   logic [WIDTH-1:0] w_calc_hi, w_calc_lo;
   logic             w_launch, w_complete, w_mthi, w_mtlo;

   mdu_calc #(
      .WIDTH (WIDTH)
   ) u_calc (
      .i_a    (A),
      .i_b    (B),
      .i_op   (MDUOp),
      .i_hi   (r_hi),
      .i_lo   (r_lo),
      .o_hi_n (w_calc_hi),
      .o_lo_n (w_calc_lo)
   );

   assign w_load_cnt = is_div_op(MDUOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_n;
   end

   // FSM next state plus launch/complete/move strobes; requests are only honoured when idle
   always_comb begin
      w_state_n  = r_state;
      w_launch   = 1'b0;
      w_complete = 1'b0;
      w_mthi     = 1'b0;
      w_mtlo     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (is_long_op(MDUOp)) begin
                  w_launch  = 1'b1;
                  w_state_n = S_BUSY;
               end
               w_mthi = (MDUOp == MDU_MTHI);
               w_mtlo = (MDUOp == MDU_MTLO);
            end
         end
         S_BUSY: begin
            if (r_cnt == CNT_W'(1)) begin
               w_complete = 1'b1;
               w_state_n  = S_IDLE;
            end
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   // Latency counter and pending result captured at launch
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt     <= '0;
         r_pend_hi <= '0;
         r_pend_lo <= '0;
      end else if (w_launch) begin
         r_cnt     <= w_load_cnt;
         r_pend_hi <= w_calc_hi;
         r_pend_lo <= w_calc_lo;
      end else if (r_state == S_BUSY) begin
         r_cnt     <= r_cnt - CNT_W'(1);
      end
   end

   // Architectural HI/LO: written only on completion or an idle mthi/mtlo
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_complete) begin
         r_hi <= r_pend_hi;
         r_lo <= r_pend_lo;
      end else begin
         if (w_mthi) r_hi <= A;
         if (w_mtlo) r_lo <= A;
      end
   end

   assign busy = (r_state == S_BUSY);
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule
